// File: rtl/bcd_timekeeper_if.sv
// bcd_timekeeper_if: control, load and display signals of the BCD time-of-day counter.
interface bcd_timekeeper_if;
    logic        run;
    logic        hour_12;
    logic        inc_hrs;
    logic        inc_min;
    logic        clr_sec;
    logic        load_valid;
    logic [23:0] load_time;
    logic [1:0]  disp_hrs_d;
    logic [3:0]  disp_hrs_u;
    logic [2:0]  min_d;
    logic [3:0]  min_u;
    logic [2:0]  sec_d;
    logic [3:0]  sec_u;
    logic        pm;
    logic        sec_tick;
    logic        blink;
    logic        load_err;

    modport master (
        output run, hour_12, inc_hrs, inc_min, clr_sec, load_valid, load_time,
        input  disp_hrs_d, disp_hrs_u, min_d, min_u, sec_d, sec_u, pm, sec_tick, blink, load_err
    );

    modport slave (
        input  run, hour_12, inc_hrs, inc_min, clr_sec, load_valid, load_time,
        output disp_hrs_d, disp_hrs_u, min_d, min_u, sec_d, sec_u, pm, sec_tick, blink, load_err
    );
endinterface

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: 24-hour BCD time-of-day counter with prescaler, adjust, checked load
// and registered 12/24-hour display outputs for the VGA clock digit renderer.
module bcd_timekeeper #(
    parameter int CLK_HZ    = 31_500_000,
    parameter int RESET_HRS = 17,
    parameter int RESET_MIN = 17,
    parameter int RESET_SEC = 0
) (
    input logic             px_clk,
    input logic             reset,
    bcd_timekeeper_if.slave bus
);
    localparam int              PW     = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   P_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]   P_HALF = PW'(CLK_HZ / 2);
    localparam logic [1:0]      R_HD   = 2'(RESET_HRS / 10);
    localparam logic [3:0]      R_HU   = 4'(RESET_HRS % 10);
    localparam logic [2:0]      R_MD   = 3'(RESET_MIN / 10);
    localparam logic [3:0]      R_MU   = 4'(RESET_MIN % 10);
    localparam logic [2:0]      R_SD   = 3'(RESET_SEC / 10);
    localparam logic [3:0]      R_SU   = 4'(RESET_SEC % 10);
    localparam logic            R_PM   = RESET_HRS >= 12;

    logic [PW-1:0] presc;
    logic [1:0]    hd, hd_i, l_hd, dh_d;
    logic [3:0]    hu, hu_i, l_hu, dh_u;
    logic [2:0]    md, md_i, l_md;
    logic [3:0]    mu, mu_i, l_mu;
    logic [2:0]    sd, sd_n, l_sd;
    logic [3:0]    su, su_n, l_su;
    logic [4:0]    h_bin, h_disp;
    logic          tick, adj, ld_ok, su_c, sd_c, m_wrap, h_wrap, unused_hi;

    // Incremented digit sets feed both the tick carry chain and the adjust buttons.
    always_comb begin
        {l_hd, l_hu, l_md, l_mu, l_sd, l_su} = bus.load_time[19:0];
        unused_hi = ^bus.load_time[23:20];
        ld_ok  = (l_hd < 2'd2 ? l_hu <= 4'd9 : l_hd == 2'd2 && l_hu <= 4'd3)
                 && l_md <= 3'd5 && l_mu <= 4'd9 && l_sd <= 3'd5 && l_su <= 4'd9;
        tick   = bus.run && presc == P_MAX;
        adj    = bus.inc_hrs || bus.inc_min || bus.clr_sec;
        su_c   = su == 4'd9;
        su_n   = su_c ? 4'd0 : su + 4'd1;
        sd_c   = su_c && sd == 3'd5;
        sd_n   = su_c ? (sd == 3'd5 ? 3'd0 : sd + 3'd1) : sd;
        m_wrap = mu == 4'd9 && md == 3'd5;
        mu_i   = mu == 4'd9 ? 4'd0 : mu + 4'd1;
        md_i   = mu == 4'd9 ? (md == 3'd5 ? 3'd0 : md + 3'd1) : md;
        h_wrap = hd == 2'd2 && hu == 4'd3;
        hu_i   = h_wrap || hu == 4'd9 ? 4'd0 : hu + 4'd1;
        hd_i   = h_wrap ? 2'd0 : hu == 4'd9 ? hd + 2'd1 : hd;
        h_bin  = 5'(hd) * 5'd10 + 5'(hu);
        h_disp = !bus.hour_12 ? h_bin : h_bin == 5'd0 ? 5'd12 : h_bin > 5'd12 ? h_bin - 5'd12 : h_bin;
        dh_d   = h_disp >= 5'd20 ? 2'd2 : h_disp >= 5'd10 ? 2'd1 : 2'd0;
        dh_u   = 4'(h_disp - 5'(dh_d) * 5'd10);
    end

    assign bus.blink = presc < P_HALF;

    // A rejected load leaves the prescaler running; clr_sec only counts when no load is present.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            presc        <= '0;
            bus.sec_tick <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            presc        <= (bus.load_valid ? ld_ok : bus.clr_sec) ? '0
                            : !bus.run ? presc : tick ? '0 : presc + 1'b1;
            bus.sec_tick <= tick;
            bus.load_err <= bus.load_valid && !ld_ok;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            {hd, hu, md, mu, sd, su} <= {R_HD, R_HU, R_MD, R_MU, R_SD, R_SU};
        end else if (bus.load_valid) begin
            if (ld_ok) {hd, hu, md, mu, sd, su} <= bus.load_time[19:0];
        end else if (adj) begin
            if (bus.inc_hrs) {hd, hu} <= {hd_i, hu_i};
            if (bus.inc_min) {md, mu} <= {md_i, mu_i};
            if (bus.clr_sec) {sd, su} <= '0;
        end else if (tick) begin
            {sd, su} <= {sd_n, su_n};
            if (sd_c) {md, mu} <= {md_i, mu_i};
            if (sd_c && m_wrap) {hd, hu} <= {hd_i, hu_i};
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            bus.disp_hrs_d <= R_HD;
            bus.disp_hrs_u <= R_HU;
            bus.min_d      <= R_MD;
            bus.min_u      <= R_MU;
            bus.sec_d      <= R_SD;
            bus.sec_u      <= R_SU;
            bus.pm         <= R_PM;
        end else begin
            bus.disp_hrs_d <= dh_d;
            bus.disp_hrs_u <= dh_u;
            bus.min_d      <= md;
            bus.min_u      <= mu;
            bus.sec_d      <= sd;
            bus.sec_u      <= su;
            bus.pm         <= h_bin >= 5'd12;
        end
    end
endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
- Parametrised time-of-day counter for the VGA clock.
- Holds hours, minutes and seconds as BCD digits and advances them from a prescaler on px_clk.
- Adds run/stop, button adjust, bulk load with validity checking, 12/24-hour display conversion, and 1 Hz tick/blink outputs.
- Feeds the digit renderer's number mux directly; a single-edge carry chain replaces ad-hoc per-digit wrap logic.

Parameters:
- CLK_HZ, 31_500_000, px_clk cycles per second; must be >= 2.
- RESET_HRS, 17, hour loaded at reset (binary, 0..23).
- RESET_MIN, 17, minute loaded at reset (0..59).
- RESET_SEC, 0, second loaded at reset (0..59).

Ports:
- px_clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = prescaler counts; 0 = time frozen.
- hour_12  in  1  1 = display outputs in 12-hour form.
- inc_hrs  in  1  single-cycle pulse: hours +1.
- inc_min  in  1  single-cycle pulse: minutes +1.
- clr_sec  in  1  single-cycle pulse: seconds and prescaler to 0.
- load_valid  in  1  load request, single cycle.
- load_time  in  24  BCD {hrs_d[1:0], hrs_u[3:0], min_d[2:0], min_u[3:0], sec_d[2:0], sec_u[3:0]}, MSB first; 20 bits used, upper 4 bits ignored.
- disp_hrs_d  out  2  displayed hours tens.
- disp_hrs_u  out  4  displayed hours units.
- min_d  out  3  minutes tens.
- min_u  out  4  minutes units.
- sec_d  out  3  seconds tens.
- sec_u  out  4  seconds units.
- pm  out  1  1 when internal hour is 12..23.
- sec_tick  out  1  one-cycle pulse per second.
- blink  out  1  1 Hz square wave.
- load_err  out  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset, synchronous on px_clk:
  - Time registers take the RESET_* values.
  - Prescaler = 0; sec_tick, load_err = 0.
  - disp_* and pm show the 24-hour form of the reset time.
- Internal time is always 24-hour BCD.
- Prescaler:
  - Counts 0..CLK_HZ-1 while run=1, then wraps to 0.
  - The wrap edge is a "tick"; sec_tick is high for exactly the cycle after a tick.
  - run=0 holds the prescaler and produces no ticks.
- Tick advance, in one edge with full carry:
  - sec_u 9->0 carries into sec_d; 59->00 carries into minutes; minutes 59->00 carries into hours; 23:59:59 -> 00:00:00.
  - Every digit stays within its legal range at all times.
- Priority per cycle: reset > load_valid > (inc_hrs | inc_min | clr_sec) > tick.
- Load:
  - Accepted only when all digits are legal and hours <= 23, minutes <= 59, seconds <= 59.
  - Accept: time := load_time, prescaler := 0.
  - Reject: time unchanged, load_err pulses the next cycle.
  - Any coincident adjust pulses and tick advance are discarded.
- Adjust:
  - inc_min wraps 59->00 with no hour carry; inc_hrs wraps 23->00. Neither touches seconds.
  - Both pulses in the same cycle apply both.
  - clr_sec zeroes seconds and the prescaler; it may combine with inc_*.
  - On any adjust cycle, a coincident tick's time advance is discarded; the prescaler still wraps and sec_tick still pulses.
- Adjust and load work with run=0.
- blink = 1 while prescaler < CLK_HZ/2 (integer division), else 0.
- Display outputs are registered, one cycle behind the internal time:
  - hour_12=0: disp_hrs = internal hour.
  - hour_12=1: 0 -> 12; 1..12 unchanged; 13..23 -> hour-12.
  - pm is independent of hour_12.
  - Minute and second outputs are also registered and aligned with disp_hrs.
- Reset asserted mid-operation overrides everything on that edge; pending pulses are lost.

Test Plan:
- CLK_HZ=10, reset released, run=1 -> 12:00 display reads 17:17:00; after 10 cycles sec_u=1; sec_tick high exactly 1 cycle in 10; blink high 5 cycles, low 5.
- Load 23:59:59, then wait for one tick -> 00:00:00 with pm=0; load 09:59:59 plus one tick -> 10:00:00.
- hour_12=1 with loads 00:30:00, 12:05:00, 13:00:00 -> disp hours 12/pm=0, 12/pm=1, 01/pm=1; with hour_12=0 the same loads read 00, 12, 13.
- Load 24:00:00, then 12:60:00, then 12:0A:00 -> each rejected, load_err pulses once, time unchanged.
- Set time 10:59:30 and pulse inc_min on the tick cycle -> 10:00:30; seconds not advanced that tick; inc_hrs at 23 -> 00.
- run=0 for 50 cycles -> time, prescaler and blink frozen, no sec_tick; clr_sec mid-second -> sec=00, next tick occurs exactly CLK_HZ cycles later.
